jtag_shift_engine: RTL and testbench

Synthesizable, parametrised successor to the DPI-driven JTAG stimulus driver. It accepts shift commands (up to MAX_BITS TMS/TDI bit pairs) over a valid/ready interface and generates TCK at a runtime-programmable divide ratio. It captures TDO on every rising TCK edge and returns the captured vector over a response handshake. It sits between a debug-transport front end (DMI bridge, host mailbox, or testbench) and the JTAG pins of the DTM.

---
 rtl/jtag_pkg.sv | 38 +++
 rtl/jtag_tap_tracker.sv | 46 ++++
 rtl/jtag_shift_engine.sv | 152 +++++++++++++++
 tb/tb_jtag_shift_engine.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// rtl/jtag_pkg.sv - shared types and pin reset values for the JTAG shift engine
package jtag_pkg;

    // IEEE 1149.1 TAP controller states
    typedef enum logic [3:0] {
        EXIT2_DR         = 4'h0,
        EXIT1_DR         = 4'h1,
        SHIFT_DR         = 4'h2,
        PAUSE_DR         = 4'h3,
        SELECT_IR_SCAN   = 4'h4,
        UPDATE_DR        = 4'h5,
        CAPTURE_DR       = 4'h6,
        SELECT_DR_SCAN   = 4'h7,
        EXIT2_IR         = 4'h8,
        EXIT1_IR         = 4'h9,
        SHIFT_IR         = 4'hA,
        PAUSE_IR         = 4'hB,
        RUN_TEST_IDLE    = 4'hC,
        UPDATE_IR        = 4'hD,
        CAPTURE_IR       = 4'hE,
        TEST_LOGIC_RESET = 4'hF
    } tap_state_e;

    // Shift engine sequencing states
    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_LOW  = 2'd1,
        ENG_HIGH = 2'd2,
        ENG_RESP = 2'd3
    } eng_state_e;

    // Pin levels applied by reset
    localparam logic TCK_RST   = 1'b0;
    localparam logic TMS_RST   = 1'b1;
    localparam logic TDI_RST   = 1'b0;
    localparam logic TRSTN_RST = 1'b0;

endpackage

// File: rtl/jtag_tap_tracker.sv
// rtl/jtag_tap_tracker.sv - 16-state TAP controller mirror advanced on rising TCK
module jtag_tap_tracker
    import jtag_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       tck_rise,
    input  logic       tms,
    input  logic       trstn,
    output tap_state_e tap_state
);

    function automatic tap_state_e next_state(input tap_state_e s, input logic m);
        tap_state_e n;
        case (s)
            TEST_LOGIC_RESET: n = m ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    n = m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_DR_SCAN:   n = m ? SELECT_IR_SCAN   : CAPTURE_DR;
            CAPTURE_DR:       n = m ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         n = m ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         n = m ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         n = m ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         n = m ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        n = m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            SELECT_IR_SCAN:   n = m ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       n = m ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         n = m ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         n = m ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         n = m ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         n = m ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        n = m ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
            default:          n = TEST_LOGIC_RESET;
        endcase
        return n;
    endfunction

    // Advance on each TCK rise; an asserted TRSTn pins the TAP in reset
    always_ff @(posedge clock) begin
        if (reset || !trstn) begin
            tap_state <= TEST_LOGIC_RESET;
        end else if (tck_rise) begin
            tap_state <= next_state(tap_state, tms);
        end
    end

endmodule

// File: rtl/jtag_shift_engine.sv
// rtl/jtag_shift_engine.sv - JTAG shift engine with programmable TCK divider; optional JTAG_TAP_TRACK_EN adds tap_state
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter int MAX_BITS = 32,
    parameter int DIV_W    = 16,
    parameter int LEN_W    = $clog2(MAX_BITS)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                init_done,
    input  logic [DIV_W-1:0]    div,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [MAX_BITS-1:0] cmd_tms,
    input  logic [MAX_BITS-1:0] cmd_tdi,
    input  logic                cmd_trstn,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_tdo,
    output logic                busy,
    output logic                jtag_TCK,
    output logic                jtag_TMS,
    output logic                jtag_TDI,
    output logic                jtag_TRSTn,
    input  logic                jtag_TDO_data,
    input  logic                jtag_TDO_driven
`ifdef JTAG_TAP_TRACK_EN
    ,
    output tap_state_e          tap_state
`endif
);

    eng_state_e          state;
    logic                init_done_sticky;
    logic [MAX_BITS-1:0] tms_q;
    logic [MAX_BITS-1:0] tdi_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx;
    logic [LEN_W-1:0]    idx_next;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    cnt;
    logic                tdo_sample;

    // An undriven TDO reads as a deterministic 0
    assign tdo_sample = jtag_TDO_driven & jtag_TDO_data;
    assign idx_next   = idx + LEN_W'(1);
    assign cmd_ready  = (state == ENG_IDLE) && enable && init_done_sticky;

    // Remember that initialisation completed, even if init_done was a pulse
    always_ff @(posedge clock) begin
        if (reset) begin
            init_done_sticky <= 1'b0;
        end else if (init_done) begin
            init_done_sticky <= 1'b1;
        end
    end

    // Command sequencer: half-period counting, pin drive, TDO capture and response hold
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ENG_IDLE;
            tms_q      <= '0;
            tdi_q      <= '0;
            len_q      <= '0;
            idx        <= '0;
            div_q      <= '0;
            cnt        <= '0;
            rsp_tdo    <= '0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
            jtag_TCK   <= TCK_RST;
            jtag_TMS   <= TMS_RST;
            jtag_TDI   <= TDI_RST;
            jtag_TRSTn <= TRSTN_RST;
        end else begin
            case (state)
                ENG_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        tms_q      <= cmd_tms;
                        tdi_q      <= cmd_tdi;
                        len_q      <= cmd_len;
                        div_q      <= div;
                        cnt        <= div;
                        idx        <= '0;
                        rsp_tdo    <= '0;
                        busy       <= 1'b1;
                        jtag_TCK   <= 1'b0;
                        jtag_TMS   <= cmd_tms[0];
                        jtag_TDI   <= cmd_tdi[0];
                        jtag_TRSTn <= cmd_trstn;
                        state      <= ENG_LOW;
                    end
                end
                ENG_LOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        jtag_TCK     <= 1'b1;
                        rsp_tdo[idx] <= tdo_sample;
                        cnt          <= div_q;
                        state        <= ENG_HIGH;
                    end
                end
                ENG_HIGH: begin
                    if (cnt != '0) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        jtag_TCK <= 1'b0;
                        if (idx == len_q) begin
                            rsp_valid <= 1'b1;
                            state     <= ENG_RESP;
                        end else begin
                            idx      <= idx_next;
                            jtag_TMS <= tms_q[idx_next];
                            jtag_TDI <= tdi_q[idx_next];
                            cnt      <= div_q;
                            state    <= ENG_LOW;
                        end
                    end
                end
                ENG_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= ENG_IDLE;
                    end
                end
                default: state <= ENG_IDLE;
            endcase
        end
    end

`ifdef JTAG_TAP_TRACK_EN
    logic tck_rise;

    // The TAP sees a rising TCK on the same edge the engine raises it
    assign tck_rise = (state == ENG_LOW) && (cnt == '0);

    jtag_tap_tracker u_tap_tracker (
        .clock     (clock),
        .reset     (reset),
        .tck_rise  (tck_rise),
        .tms       (jtag_TMS),
        .trstn     (jtag_TRSTn),
        .tap_state (tap_state)
    );
`endif

endmodule

// File: tb/tb_jtag_shift_engine.sv
// tb/tb_jtag_shift_engine.sv - randomized scoreboard bench for jtag_shift_engine
module tb_jtag_shift_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        init_done;
    logic [15:0] div;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_tms;
    logic [31:0] cmd_tdi;
    logic        cmd_trstn;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_tdo;
    logic        busy;
    logic        jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn;
    logic        jtag_TDO_data, jtag_TDO_driven;
`ifdef JTAG_TAP_TRACK_EN
    jtag_pkg::tap_state_e tap_state;
`endif

    jtag_shift_engine dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .init_done       (init_done),
        .div             (div),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_len         (cmd_len),
        .cmd_tms         (cmd_tms),
        .cmd_tdi         (cmd_tdi),
        .cmd_trstn       (cmd_trstn),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tdo         (rsp_tdo),
        .busy            (busy),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven)
`ifdef JTAG_TAP_TRACK_EN
        ,
        .tap_state       (tap_state)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] tdo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rise_total = 0;
    int          rise_base = 0;
    logic        tck_prev = 1'b0;
    logic [31:0] tdo_pat = '0;
    logic        tdo_drv = 1'b0;
    logic        tdo_loop = 1'b0;
    logic [4:0]  tdo_idx;
    logic        bp_hold = 1'b0;

    // Pin-level view of the command currently on the wire
    logic        act_on = 1'b0;
    int          act_acc = 0;
    int          act_len = 0;
    int          act_d = 0;
    int          act_lat = 0;
    logic [31:0] act_tms = '0;
    logic [31:0] act_tdi = '0;
    logic        act_trstn = 1'b0;
    int          wave_err = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // TDO target: bit k is presented until the k-th TCK rise has been seen
    always @(negedge clock) begin
        if (jtag_TCK && !tck_prev) rise_total++;
        tck_prev = jtag_TCK;
    end
    assign tdo_idx         = 5'(rise_total - rise_base);
    assign jtag_TDO_data   = tdo_loop ? jtag_TDI : tdo_pat[tdo_idx];
    assign jtag_TDO_driven = tdo_drv;

    // Consumer with random backpressure
    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clock);
            #2;
            rsp_ready = bp_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out (cycle %0d)", name, cyc);
    endtask

    // Monitor: pin waveform vs. ideal timing, response latency and data
    initial begin
        int   c;
        int   b;
        int   per;
        logic exp_tck;
        logic valid_seen;
        logic post_hs;
        exp_t e;
        valid_seen = 1'b0;
        post_hs    = 1'b0;
        forever begin
            @(negedge clock);
            if (act_on) begin
                c   = cyc - act_acc;
                per = act_d + 1;
                if (c < act_lat) begin
                    exp_tck = ((c / per) % 2) == 1;
                    b       = c / (2 * per);
                end else begin
                    exp_tck = 1'b0;
                    b       = act_len;
                end
                if (jtag_TCK !== exp_tck || jtag_TMS !== act_tms[b] ||
                    jtag_TDI !== act_tdi[b] || jtag_TRSTn !== act_trstn)
                    wave_err++;
            end
            if (post_hs) begin
                check("ready_after_rsp", {31'b0, cmd_ready}, {31'b0, enable});
                post_hs = 1'b0;
            end
            if (rsp_valid) begin
                if (!valid_seen) begin
                    valid_seen = 1'b1;
                    if (exp_q.size() != 0)
                        check("rsp_latency", cyc - act_acc, exp_q[0].lat);
                    check("ready_during_rsp", {31'b0, cmd_ready}, 32'd0);
                end
                if (rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        timeout("unexpected_rsp");
                    end else begin
                        e = exp_q.pop_front();
                        check("rsp_tdo", rsp_tdo, e.tdo);
                        check("pin_waveform", wave_err, 32'd0);
                    end
                    wave_err   = 0;
                    valid_seen = 1'b0;
                    post_hs    = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input int len, input logic [31:0] tms, input logic [31:0] tdi,
                        input logic [31:0] pat, input logic trstn, input int d,
                        input logic drv, input logic loop);
        int   n;
        exp_t e;
        n = 0;
        while (!cmd_ready && n < 5000) begin
            tick(1);
            n++;
        end
        if (!cmd_ready) begin
            timeout("accept_wait");
            return;
        end
        cmd_len    = 5'(len);
        cmd_tms    = tms;
        cmd_tdi    = tdi;
        cmd_trstn  = trstn;
        div        = 16'(d);
        tdo_pat    = pat;
        tdo_drv    = drv;
        tdo_loop   = loop;
        rise_base  = rise_total;
        cmd_valid  = 1'b1;
        tick(1);
        cmd_valid  = 1'b0;
        act_acc    = cyc;
        act_len    = len;
        act_d      = d;
        act_lat    = 2 * (len + 1) * (d + 1);
        act_tms    = tms;
        act_tdi    = tdi;
        act_trstn  = trstn;
        act_on     = 1'b1;
        e.tdo = '0;
        for (int k = 0; k <= len; k++)
            e.tdo[k] = drv ? (loop ? tdi[k] : pat[k]) : 1'b0;
        e.lat = act_lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < 5000) begin
            tick(1);
            n++;
        end
        if (busy || exp_q.size() != 0) timeout("idle_wait");
    endtask

    task automatic pulse_init();
        init_done = 1'b1;
        tick(1);
        init_done = 1'b0;
    endtask

    initial begin
        logic [31:0] snap;
        logic        bad;
        int          n;
        reset = 1'b1; enable = 1'b0; init_done = 1'b0; div = '0;
        cmd_valid = 1'b0; cmd_len = '0; cmd_tms = '0; cmd_tdi = '0; cmd_trstn = 1'b0;
        tick(3);
        check("rst_tck",   {31'b0, jtag_TCK},   32'd0);
        check("rst_tms",   {31'b0, jtag_TMS},   32'd1);
        check("rst_tdi",   {31'b0, jtag_TDI},   32'd0);
        check("rst_trstn", {31'b0, jtag_TRSTn}, 32'd0);
        check("rst_ready", {31'b0, cmd_ready},  32'd0);
        check("rst_valid", {31'b0, rsp_valid},  32'd0);
        check("rst_busy",  {31'b0, busy},       32'd0);
        check("rst_tdo",   rsp_tdo,             32'd0);
        reset = 1'b0;

        // Gating: enable alone is not enough, a single init pulse sticks
        enable = 1'b1;
        tick(3);
        check("ready_before_init", {31'b0, cmd_ready}, 32'd0);
        pulse_init();
        tick(3);
        check("ready_after_init", {31'b0, cmd_ready}, 32'd1);

        // Basic loopback shift
        send(3, $urandom, 32'h0000_000A, '0, 1'b1, 0, 1'b1, 1'b1);
        wait_idle();

        // Divider of 4 with a mid-command div change
        send(0, $urandom, $urandom, $urandom, 1'b1, 4, 1'b1, 1'b0);
        tick(2);
        div = 16'd9;
        wait_idle();

        // Undriven TDO reads as zero
        send(7, $urandom, $urandom, 32'hFFFF_FFFF, 1'b1, 1, 1'b0, 1'b0);
        wait_idle();

        // Full width alternating pattern
        send(31, $urandom, $urandom, 32'h5555_5555, 1'b1, 0, 1'b1, 1'b0);
        wait_idle();

        // Backpressure: response holds for 20 cycles
        bp_hold = 1'b1;
        send(5, $urandom, $urandom, $urandom, 1'b1, 1, 1'b1, 1'b0);
        n = 0;
        while (!rsp_valid && n < 500) begin
            tick(1);
            n++;
        end
        if (!rsp_valid) timeout("bp_rsp_wait");
        snap = rsp_tdo;
        bad  = 1'b0;
        repeat (20) begin
            tick(1);
            if (!rsp_valid || rsp_tdo !== snap || jtag_TCK || cmd_ready) bad = 1'b1;
        end
        check("backpressure_hold", {31'b0, bad}, 32'd0);
        bp_hold = 1'b0;
        wait_idle();

        // Dropping enable mid-command lets it complete but blocks the next accept
        send(15, $urandom, $urandom, $urandom, 1'b1, 1, 1'b1, 1'b0);
        tick(3);
        enable = 1'b0;
        wait_idle();
        tick(1);
        check("ready_enable_low", {31'b0, cmd_ready}, 32'd0);
        enable = 1'b1;

        // Randomized commands
        for (int r = 0; r < 25; r++) begin
            send($urandom_range(0, 31), $urandom, $urandom, $urandom, 1'($urandom),
                 $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 6));
        end
        wait_idle();

        // Reset in the middle of bit 5
        send(10, $urandom, $urandom, $urandom, 1'b1, 1, 1'b1, 1'b0);
        tick(21);
        act_on = 1'b0;
        reset  = 1'b1;
        tick(1);
        exp_q.delete();
        check("midrst_tck",   {31'b0, jtag_TCK},   32'd0);
        check("midrst_tms",   {31'b0, jtag_TMS},   32'd1);
        check("midrst_trstn", {31'b0, jtag_TRSTn}, 32'd0);
        check("midrst_valid", {31'b0, rsp_valid},  32'd0);
        check("midrst_busy",  {31'b0, busy},       32'd0);
        check("midrst_tdo",   rsp_tdo,             32'd0);
`ifdef JTAG_TAP_TRACK_EN
        check("tap_reset", {28'b0, tap_state}, {28'b0, jtag_pkg::TEST_LOGIC_RESET});
`endif
        reset = 1'b0;
        tick(2);
        check("ready_after_rst", {31'b0, cmd_ready}, 32'd0);
        pulse_init();

`ifdef JTAG_TAP_TRACK_EN
        // Five TMS=1 then 0,1,0,0 walks the TAP to SHIFT_DR
        send(8, 32'h0000_005F, $urandom, $urandom, 1'b1, 0, 1'b1, 1'b0);
        wait_idle();
        check("tap_shift_dr", {28'b0, tap_state}, {28'b0, jtag_pkg::SHIFT_DR});
`endif

        send(4, $urandom, $urandom, $urandom, 1'b1, 2, 1'b1, 1'b1);
        wait_idle();
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
